breakout_mem_arbiter: RTL
=========================

Name: breakout_mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 32K x 32 on-chip memory (15-bit word address, 4 byte enables, 1-cycle registered-address read) between the Nios data master (requester 0) and the frame/sprite fetch engine (requester 1).
- Accepts at most one access per cycle, using round-robin between requesters.
- Returns read data to the issuing requester with a fixed latency, tagged through an owner pipeline.
- Sits between both masters and the memory's s1 slave interface.

Parameters:
- ADDR_W, 15, word address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).
- RD_LAT, 1, memory read latency in cycles (depth of the owner pipeline, 1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- r0_address / r1_address  in  ADDR_W  requester word address.
- r0_byteenable / r1_byteenable  in  DATA_W/8  byte lanes for writes.
- r0_read / r1_read  in  1  read request.
- r0_write / r1_write  in  1  write request.
- r0_writedata / r1_writedata  in  DATA_W  write data.
- r0_waitrequest / r1_waitrequest  out  1  high = request not accepted this cycle.
- r0_readdata / r1_readdata  out  DATA_W  read return data.
- r0_readdatavalid / r1_readdatavalid  out  1  one-cycle strobe when readdata is valid.
- mem_address  out  ADDR_W  to memory address.
- mem_byteenable  out  DATA_W/8  to memory byteenable.
- mem_chipselect  out  1  to memory chipselect.
- mem_write  out  1  to memory write.
- mem_writedata  out  DATA_W  to memory writedata.
- mem_clken  out  1  to memory clken; constant 1.
- mem_readdata  in  DATA_W  from memory readdata.

Behaviour:
- Request: rN_req = rN_read | rN_write. If read and write are asserted together, treat as a write; the read is dropped.
- Grant: combinational from the requests and a registered priority pointer `pri` (0 or 1).
  - Only one requester asking: that requester wins.
  - Both asking: requester `pri` wins.
  - Winner's waitrequest = 0 in the same cycle.
  - Loser's waitrequest = 1. Idle requester's waitrequest = 0 (Avalon: don't-care when idle).
- Priority pointer: on any accepted access, `pri` <= 1 - winner on the next edge. With no access, `pri` holds.
  - Under continuous contention, grants strictly alternate 0,1,0,1.
- Memory command: combinational mux of the winner's fields.
  - mem_chipselect = any grant.
  - mem_write = winner_is_write.
  - No grant: chipselect = 0, write = 0, address/byteenable/writedata = 0.
- Owner pipeline: RD_LAT stages of {valid, owner}.
  - Stage 0 loads {granted read, winner}; writes load valid = 0.
  - At stage RD_LAT-1 output, when valid is set, rOWNER_readdatavalid = 1 and rOWNER_readdata = mem_readdata.
  - Read data returns exactly RD_LAT cycles after acceptance.
- readdata ports:
  - readdata is driven from mem_readdata to both requesters unconditionally; only the matching readdatavalid qualifies it.
  - readdatavalid is registered from the pipeline, not combinational from requests.
- Back-to-back: a read can be accepted every cycle. Returns stay in issue order and never overlap, because only one read is issued per cycle.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data. Both are single-cycle accesses to the memory's single port.
- Reset (async): `pri` = 0; all pipeline valid bits = 0.
  - While reset is high, readdatavalid = 0 on both requesters and mem_chipselect = 0.
  - Reset mid-read discards the in-flight return; no readdatavalid is produced after deassertion.
- Reset values of outputs:
  - waitrequest: both 0, since no request is granted and mem_chipselect is forced low.
  - readdatavalid: both 0.
  - mem_*: all 0 except mem_clken = 1.

Decomposition:
- Shared package breakout_mem_pkg:
  - ADDR_W, DATA_W constants.
  - Typedef mem_req_t {addr, be, rd, wr, wdata}.
  - Typedef owner_t (1 bit).
- One sub-module, breakout_rr_arb2: 2-way round-robin grant with `pri` register. Inputs req[1:0] and accept; outputs gnt[1:0].
- Owner pipeline and the muxes are in the top level.

Test Plan:
- Single read: preload mem[0x0010] = 0xCAFE_F00D; r0 reads 0x0010. Expect r0_waitrequest = 0, and r0_readdatavalid one cycle later with 0xCAFE_F00D. r1_readdatavalid stays 0.
- Contention: after reset, r0 and r1 read continuously for 6 cycles. Expect grant order 0,1,0,1,0,1. Each readdatavalid arrives RD_LAT cycles after its grant, with the correct owner's data.
- Byte write: r1 writes 0xAABBCCDD, be = 4'b0101 to 0x7FFF (top address), where the old value is 0x11223344. The following r1 read returns 0x11BB33DD.
- Write-then-read: r0 writes 0x12345678 to 0x0400; on the next cycle r1 reads 0x0400. Expect r1 to get 0x12345678 one cycle later.
- Read+write together: r0 asserts read and write together to 0x0001 with data 0x5. Expect the memory to be written and no r0_readdatavalid.
- Async reset mid-read: assert reset between acceptance and return. Expect readdatavalid = 0 immediately and no valid strobe after release. After release, a contended request goes to r0 first (`pri` = 0).

Source files
------------

// File: rtl/breakout_mem_pkg.sv
// Shared types and constants for the breakout on-chip memory arbiter.
// The memory is a 32K x 32 single-port RAM with byte enables and a 1-cycle read.
package breakout_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef logic owner_t;

  localparam owner_t OWNER_R0 = 1'b0;
  localparam owner_t OWNER_R1 = 1'b1;

  // Grants are one-hot, so requester 1 owns the access exactly when its bit is set.
  function automatic owner_t gnt_to_owner(input logic [1:0] gnt);
    return owner_t'(gnt[1]);
  endfunction

endpackage

// File: rtl/breakout_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant from the requests
// and a registered priority pointer that moves past each accepted winner.
module breakout_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic pri_q;
  logic pri_d;

  always_comb begin
    // NOTE: give every combinationally driven signal a default first so that
    // no path through the case leaves it unassigned and infers a latch.
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pri_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // The pointer targets the requester that did not just win; idle cycles hold it.
  always_comb begin
    pri_d = pri_q;
    if (accept) begin
      pri_d = ~gnt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    if (reset) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/breakout_mem_arbiter.sv
// Shares the single-port on-chip memory between the Nios data master (r0) and
// the frame/sprite fetch engine (r1); read data is steered back by an owner pipeline.
module breakout_mem_arbiter #(
  parameter int ADDR_W = breakout_mem_pkg::ADDR_W,
  parameter int DATA_W = breakout_mem_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,

  input  logic [ADDR_W-1:0]   r0_address,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,

  input  logic [ADDR_W-1:0]   r1_address,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  import breakout_mem_pkg::*;

  logic [1:0] req;
  logic [1:0] gnt;
  mem_req_t   r0_cmd;
  mem_req_t   r1_cmd;
  mem_req_t   win_cmd;
  logic       issue_rd;
  owner_t     issue_owner;

  logic   [RD_LAT-1:0] vld_q;
  owner_t [RD_LAT-1:0] own_q;

  assign r0_cmd = '{addr: r0_address, be: r0_byteenable, rd: r0_read,
                    wr: r0_write, wdata: r0_writedata};
  assign r1_cmd = '{addr: r1_address, be: r1_byteenable, rd: r1_read,
                    wr: r1_write, wdata: r1_writedata};

  // Requests are masked during reset so nothing reaches the memory and no one stalls.
  assign req[0] = (r0_read | r0_write) & ~reset;
  assign req[1] = (r1_read | r1_write) & ~reset;

  breakout_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (|gnt),
    .gnt    (gnt)
  );

  assign r0_waitrequest = req[0] & ~gnt[0];
  assign r1_waitrequest = req[1] & ~gnt[1];

  always_comb begin
    win_cmd = '0;
    if (gnt[0]) begin
      win_cmd = r0_cmd;
    end else if (gnt[1]) begin
      win_cmd = r1_cmd;
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_write      = win_cmd.wr;
  assign mem_address    = win_cmd.addr;
  assign mem_byteenable = win_cmd.be;
  assign mem_writedata  = win_cmd.wdata;
  assign mem_clken      = 1'b1;

  // A simultaneous read+write is a write; the read half never enters the pipeline.
  assign issue_rd    = (|gnt) & win_cmd.rd & ~win_cmd.wr;
  assign issue_owner = gnt_to_owner(gnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q[0] <= issue_rd;
      own_q[0] <= issue_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
    end
  end

  assign r0_readdata      = mem_readdata;
  assign r1_readdata      = mem_readdata;
  assign r0_readdatavalid = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWNER_R0);
  assign r1_readdatavalid = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWNER_R1);

endmodule
